instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage sitting directly upstream of the instruction memory. It owns the program counter and drives the memory's read address. It captures the combinationally returned instruction word into a fetch register and splits it into MIPS-style fields for the decode/execute stage. It handles stall, branch/jump redirect, address wrap-around and halt detection.

Parameters:
ADDR_W, 9, instruction memory address width (512 words)
DATA_W, 32, instruction word width
START_PC, 9'd1, first address fetched after reset (word 0 unused by the program image)
HALT_WORD, 32'h0000_0000, instruction encoding that terminates fetch

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high; while high the instruction memory is (re)loading its image
imem_addr  output  ADDR_W  read address to instruction memory; equals current PC
imem_rdata  input  DATA_W  instruction word returned combinationally for imem_addr
stall  input  1  downstream not ready; hold PC and fetch register
redirect_valid  input  1  taken branch/jump from execute
redirect_pc  input  ADDR_W  target word address for redirect
if_valid  output  1  fetch register holds a live instruction
if_instr  output  DATA_W  registered instruction word
if_pc  output  ADDR_W  address of if_instr
if_pc_plus1  output  ADDR_W  if_pc+1, wrapped modulo 2^ADDR_W
if_opcode  output  6  if_instr[31:26]
if_rs  output  5  if_instr[25:21]
if_rt  output  5  if_instr[20:16]
if_rd  output  5  if_instr[15:11]
if_imm  output  16  if_instr[15:0], raw, no extension
if_target  output  26  if_instr[25:0]
halted  output  1  fetch stopped on HALT_WORD

Behaviour:
- Reset (async, any cycle including mid-fetch): state=SETTLE, pc=START_PC, if_valid=0, if_instr=0, if_pc=0, halted=0. Field outputs derive from if_instr, so they are all 0.
- imem_addr = pc at all times, with no register between them.
- States:
  - SETTLE: one cycle after reset deasserts so the memory image is stable; no capture; go to FETCH.
  - FETCH: normal operation.
  - HALT: terminal state.
- FETCH, priority when several events coincide: redirect_valid > stall > normal.
  - redirect_valid=1: pc<=redirect_pc, if_valid<=0 (flushes the wrong-path word). This applies even if stall=1.
  - stall=1: pc, if_instr, if_pc, if_valid unchanged.
  - normal: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+1.
- Latency: the word at address A appears on if_instr one clock after imem_addr=A. Unstalled throughput is 1 instruction/cycle.
- Wrap: pc=2^ADDR_W-1 increments to 0. if_pc_plus1 wraps the same way.
- Halt:
  - When the captured word equals HALT_WORD, it is presented with if_valid=1 for that cycle.
  - On the next unstalled edge: state<=HALT, halted<=1, if_valid<=0, pc frozen.
  - If that edge carries a redirect, the redirect wins and halt is cancelled.
  - In HALT, stall and redirect are ignored; only reset exits.
- Redirect during SETTLE: ignored.
- No arithmetic besides the ADDR_W-bit increment; field slicing is purely combinational from if_instr.

Decomposition:
- Shared package isa_pkg:
  - opcode constants: OP_RTYPE=6'b000000, OP_ADDI=6'b001000, OP_BEQ=6'b000100, OP_J=6'b000010, OP_LW=6'b100011, OP_SW=6'b101011, OP_BLE=6'b100001
  - funct constants: FN_ADD=6'b100000, FN_SUB=6'b100010
  - field width constants
  - fetch state encoding (SETTLE, FETCH, HALT)
- One natural sub-module: instr_field_split, a combinational slicer of a 32-bit word into opcode/rs/rt/rd/imm/target. It is reused later by decode.

Test Plan:
- Reset high 3 cycles, then release; memory holds addi $a1,$zero,6 at address 2 -> imem_addr=1 during SETTLE. The cycle after SETTLE shows if_valid=1, if_pc=1; the next shows if_pc=2, if_opcode=6'b001000, if_rt=5, if_imm=6.
- Free run from address 1 for 5 cycles, no stall -> if_pc sequence 1,2,3,4,5 with if_valid=1 each cycle.
- Assert stall for 3 cycles at if_pc=5 -> if_pc, if_instr, imem_addr held at 5/word5/6. On release, if_pc=6 on the next edge.
- redirect_valid=1, redirect_pc=9'd10, with stall=1 in the same cycle -> next cycle if_valid=0, imem_addr=10. The following cycle if_pc=10, if_valid=1.
- Place HALT_WORD at address 27 and run -> if_pc=27 with if_valid=1 for one cycle, then halted=1, if_valid=0. imem_addr stays at 28 and ignores redirect_pc=3; a later reset pulse restarts at pc=1.
- redirect_pc=9'd511, then free run -> if_pc 511 followed by if_pc 0, with if_pc_plus1=0 while if_pc=511.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode/funct encodings, field widths, fetch state
// encoding and the decoded-field bundle used by fetch and decode.
package isa_pkg;

  localparam int OPC_W = 6;
  localparam int REG_W = 5;
  localparam int IMM_W = 16;
  localparam int TGT_W = 26;
  localparam int FN_W  = 6;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BLE   = 6'b100001;

  localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB = 6'b100010;

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALT   = 2'd2;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    logic [TGT_W-1:0] target;
  } instr_fields_t;

endpackage

// File: rtl/instr_field_split.sv
// Purely combinational MIPS-style field slicer; shared by fetch and decode.
module instr_field_split
  import isa_pkg::*;
(
  input  logic [31:0]   instr,
  output instr_fields_t fields
);

  always_comb begin
    fields.opcode = instr[31:26];
    fields.rs     = instr[25:21];
    fields.rt     = instr[20:16];
    fields.rd     = instr[15:11];
    fields.imm    = instr[15:0];
    fields.target = instr[25:0];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives imem_addr directly from it, registers the
// returned word and exposes its fields; handles stall, redirect, wrap and halt.
module instr_fetch_unit
  import isa_pkg::*;
#(
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] START_PC  = 9'd1,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus1,
  output logic [5:0]        if_opcode,
  output logic [4:0]        if_rs,
  output logic [4:0]        if_rt,
  output logic [4:0]        if_rd,
  output logic [15:0]       if_imm,
  output logic [25:0]       if_target,
  output logic              halted
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              halt_seen;
  instr_fields_t     fields;

  assign imem_addr   = pc;
  assign if_pc_plus1 = if_pc + ADDR_W'(1);
  // if_valid qualifies the match: the reset value of if_instr equals HALT_WORD
  assign halt_seen   = if_valid && (if_instr == HALT_WORD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_SETTLE;
      pc       <= START_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      halted   <= 1'b0;
    end else begin
      case (state)
        ST_SETTLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (redirect_valid) begin
            pc       <= redirect_pc;
            if_valid <= 1'b0;
          end else if (!stall) begin
            if (halt_seen) begin
              state    <= ST_HALT;
              halted   <= 1'b1;
              if_valid <= 1'b0;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc + ADDR_W'(1);
            end
          end
        end
        default: ; // HALT: only reset leaves
      endcase
    end
  end

  instr_field_split u_split (
    .instr  (if_instr[31:0]),
    .fields (fields)
  );

  assign if_opcode = fields.opcode;
  assign if_rs     = fields.rs;
  assign if_rt     = fields.rt;
  assign if_rd     = fields.rd;
  assign if_imm    = fields.imm;
  assign if_target = fields.target;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: combinational memory model plus a
// queue of expected (pc, word) captures popped whenever if_valid is seen.
module tb_instr_fetch_unit;

  typedef struct {
    logic [8:0]  pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [8:0]  if_pc;
  logic [8:0]  if_pc_plus1;
  logic [5:0]  if_opcode;
  logic [4:0]  if_rs, if_rt, if_rd;
  logic [15:0] if_imm;
  logic [25:0] if_target;
  logic        halted;

  logic [31:0] mem [512];
  exp_t        exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr];

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus1    (if_pc_plus1),
    .if_opcode      (if_opcode),
    .if_rs          (if_rs),
    .if_rt          (if_rt),
    .if_rd          (if_rd),
    .if_imm         (if_imm),
    .if_target      (if_target),
    .halted         (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      exp_t e;
      e.pc    = 9'(first + i);
      e.instr = mem[9'(first + i)];
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) tick();
    n_cmp++;
    if (if_valid !== 1'b0 || if_pc !== 9'd0 || if_instr !== 32'd0 || halted !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b pc=%0d instr=%h halted=%b, need 0/0/0/0",
               if_valid, if_pc, if_instr, halted);
    end
    n_cmp++;
    if (imem_addr !== 9'd1 || if_opcode !== 6'd0 || if_imm !== 16'd0 || if_target !== 26'd0) begin
      n_err++;
      $display("FAIL reset_addr_fields: got addr=%0d op=%0d imm=%0d tgt=%0d, need 1/0/0/0",
               imem_addr, if_opcode, if_imm, if_target);
    end
    reset = 1'b0;
    tick(); // SETTLE edge: nothing captured
    n_cmp++;
    if (if_valid !== 1'b0 || imem_addr !== 9'd1) begin
      n_err++;
      $display("FAIL settle: got valid=%b addr=%0d, need 0/1", if_valid, imem_addr);
    end
  endtask

  task automatic test_free_run();
    push_range(1, 5);
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (if_valid !== 1'b1) begin
        n_err++;
        $display("FAIL free_run_valid: cycle %0d got valid=%b need 1", c, if_valid);
      end else if (exp_q.size() != 0) begin
        exp_t e = exp_q.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          n_err++;
          $display("FAIL free_run_sb: got pc=%0d instr=%h, need pc=%0d instr=%h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end
      if (c == 1) begin
        n_cmp++;
        if (if_opcode !== 6'b001000 || if_rs !== 5'd0 || if_rt !== 5'd5 || if_imm !== 16'd6) begin
          n_err++;
          $display("FAIL addi_fields: got op=%b rs=%0d rt=%0d imm=%0d, need 001000/0/5/6",
                   if_opcode, if_rs, if_rt, if_imm);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL free_run_drain: got %0d left, need 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (if_pc !== 9'd5 || if_instr !== mem[5] || imem_addr !== 9'd6 || if_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold: got pc=%0d instr=%h addr=%0d valid=%b, need 5/%h/6/1",
                 if_pc, if_instr, imem_addr, if_valid, mem[5]);
      end
    end
    stall = 1'b0;
    push_range(6, 1);
    tick();
    n_cmp++;
    if (if_valid === 1'b1 && exp_q.size() != 0) begin
      exp_t e = exp_q.pop_front();
      if (if_pc !== e.pc || if_instr !== e.instr) begin
        n_err++;
        $display("FAIL stall_release: got pc=%0d instr=%h, need pc=%0d instr=%h",
                 if_pc, if_instr, e.pc, e.instr);
      end
    end else begin
      n_err++;
      $display("FAIL stall_release: got valid=%b, need 1 with pc=6", if_valid);
      exp_q.delete();
    end
  endtask

  task automatic test_redirect_over_stall();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 9'd10;
    tick();
    stall = 1'b0; redirect_valid = 1'b0;
    n_cmp++;
    if (if_valid !== 1'b0 || imem_addr !== 9'd10) begin
      n_err++;
      $display("FAIL redirect_flush: got valid=%b addr=%0d, need 0/10", if_valid, imem_addr);
    end
    push_range(10, 1);
    tick();
    n_cmp++;
    if (if_valid === 1'b1 && exp_q.size() != 0) begin
      exp_t e = exp_q.pop_front();
      if (if_pc !== e.pc || if_instr !== e.instr) begin
        n_err++;
        $display("FAIL redirect_target: got pc=%0d instr=%h, need pc=%0d instr=%h",
                 if_pc, if_instr, e.pc, e.instr);
      end
    end else begin
      n_err++;
      $display("FAIL redirect_target: got valid=%b, need 1 with pc=10", if_valid);
      exp_q.delete();
    end
  endtask

  task automatic test_halt();
    logic [31:0] saved;
    saved = mem[27];
    mem[27] = 32'h0000_0000;
    redirect_valid = 1'b1; redirect_pc = 9'd20;
    tick();
    redirect_valid = 1'b0;
    push_range(20, 8);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (if_valid === 1'b1 && exp_q.size() != 0) begin
        exp_t e = exp_q.pop_front();
        n_cmp++;
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          n_err++;
          $display("FAIL halt_run_sb: got pc=%0d instr=%h, need pc=%0d instr=%h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || if_pc !== 9'd27 || if_valid !== 1'b1 || halted !== 1'b0 || imem_addr !== 9'd28) begin
      n_err++;
      $display("FAIL halt_present: got left=%0d pc=%0d valid=%b halted=%b addr=%0d, need 0/27/1/0/28",
               exp_q.size(), if_pc, if_valid, halted, imem_addr);
      exp_q.delete();
    end
    // a redirect on the halt edge cancels the halt
    redirect_valid = 1'b1; redirect_pc = 9'd25;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 9'd25) begin
      n_err++;
      $display("FAIL halt_cancel: got halted=%b valid=%b addr=%0d, need 0/0/25",
               halted, if_valid, imem_addr);
    end
    push_range(25, 3);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (if_valid === 1'b1 && exp_q.size() != 0) begin
        exp_t e = exp_q.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          n_err++;
          $display("FAIL halt_rerun_sb: got pc=%0d instr=%h, need pc=%0d instr=%h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end else begin
        n_err++;
        $display("FAIL halt_rerun_sb: got valid=%b left=%0d, need valid capture", if_valid, exp_q.size());
      end
    end
    exp_q.delete();
    stall = 1'b1;
    tick();
    stall = 1'b0;
    n_cmp++;
    if (halted !== 1'b0 || if_valid !== 1'b1 || if_pc !== 9'd27) begin
      n_err++;
      $display("FAIL halt_stalled: got halted=%b valid=%b pc=%0d, need 0/1/27", halted, if_valid, if_pc);
    end
    tick();
    n_cmp++;
    if (halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 9'd28) begin
      n_err++;
      $display("FAIL halt_enter: got halted=%b valid=%b addr=%0d, need 1/0/28", halted, if_valid, imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 9'd3;
    for (int c = 0; c < 3; c++) begin
      stall = c[0];
      tick();
      n_cmp++;
      if (halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 9'd28) begin
        n_err++;
        $display("FAIL halt_sticky: got halted=%b valid=%b addr=%0d, need 1/0/28", halted, if_valid, imem_addr);
      end
    end
    redirect_valid = 1'b0; stall = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 9'd1) begin
      n_err++;
      $display("FAIL halt_async_reset: got halted=%b valid=%b addr=%0d, need 0/0/1", halted, if_valid, imem_addr);
    end
    tick();
    reset = 1'b0;
    mem[27] = saved;
    tick(); // SETTLE
    push_range(1, 2);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (if_valid === 1'b1 && exp_q.size() != 0) begin
        exp_t e = exp_q.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          n_err++;
          $display("FAIL restart_sb: got pc=%0d instr=%h, need pc=%0d instr=%h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end else begin
        n_err++;
        $display("FAIL restart_sb: got valid=%b, need 1", if_valid);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 9'd511;
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back('{pc: 9'd511, instr: mem[511]});
    exp_q.push_back('{pc: 9'd0,   instr: mem[0]});
    exp_q.push_back('{pc: 9'd1,   instr: mem[1]});
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (if_valid === 1'b1 && exp_q.size() != 0) begin
        exp_t e = exp_q.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          n_err++;
          $display("FAIL wrap_sb: got pc=%0d instr=%h, need pc=%0d instr=%h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end else begin
        n_err++;
        $display("FAIL wrap_sb: got valid=%b, need 1", if_valid);
      end
      if (c == 0) begin
        n_cmp++;
        if (if_pc_plus1 !== 9'd0 || imem_addr !== 9'd0) begin
          n_err++;
          $display("FAIL wrap_plus1: got pc_plus1=%0d addr=%0d, need 0/0", if_pc_plus1, imem_addr);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL wrap_drain: got %0d left, need 0", exp_q.size());
    end
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = {6'b001000, 5'd0, a[4:0], 16'(a)} | 32'h2000_0000;
    mem[2] = 32'h2005_0006; // addi $a1, $zero, 6
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_over_stall();
    test_halt();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
